// File: rtl/sample_ctrl.sv
// sample: combinational CDF error sampler, one r value to one signed error sample.
// sample_ctrl: streams N = n*nbar sampler outputs from 64-bit random words.
module sample #(
   parameter int WIDTH_Q = 16
) (
   input  logic [WIDTH_Q-1:0] i_r,
   input  logic [2:0]         i_sec_level,
   output logic [WIDTH_Q-1:0] o_e
);
   localparam logic [WIDTH_Q-2:0] T1 [13] = '{15'd4643, 15'd13363, 15'd20579, 15'd25843, 15'd29227,
      15'd31145, 15'd32103, 15'd32525, 15'd32689, 15'd32745, 15'd32762, 15'd32766, 15'd32767};
   localparam logic [WIDTH_Q-2:0] T3 [11] = '{15'd5638, 15'd15915, 15'd23689, 15'd28571, 15'd31116,
      15'd32217, 15'd32613, 15'd32731, 15'd32760, 15'd32766, 15'd32767};
   localparam logic [WIDTH_Q-2:0] T5 [7] = '{15'd9142, 15'd23462, 15'd30338, 15'd32361, 15'd32725,
      15'd32765, 15'd32767};
   logic [WIDTH_Q-2:0] t;
   logic [3:0]         e1, e3, e5, mag;
   logic [WIDTH_Q-1:0] ext;
   always_comb begin
      t = i_r[WIDTH_Q-1:1];
      e1 = '0;
      e3 = '0;
      e5 = '0;
      for (int i = 0; i < 13; i++) e1 = e1 + 4'(t > T1[i]);
      for (int i = 0; i < 11; i++) e3 = e3 + 4'(t > T3[i]);
      for (int i = 0; i < 7; i++) e5 = e5 + 4'(t > T5[i]);
      mag = (i_sec_level == 3'd3) ? e3 : (i_sec_level == 3'd5) ? e5 : e1;
      ext = {{(WIDTH_Q-4){1'b0}}, mag};
      o_e = i_r[0] ? -ext : ext;
   end
endmodule

module sample_ctrl #(
   parameter int RAND_W  = 64,
   parameter int WIDTH_Q = 16,
   parameter int ADDR_W  = 14
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [2:0]         i_sec_level,
   input  logic [RAND_W-1:0]  i_rand,
   input  logic               i_rand_valid,
   output logic               o_rand_ready,
   output logic [WIDTH_Q-1:0] o_e,
   output logic [ADDR_W-1:0]  o_e_addr,
   output logic               o_e_valid,
   input  logic               i_e_ready,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err
);
   typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;
   state_t              state_q, state_d;
   logic [2:0]          lvl_q, lvl_d;
   logic [RAND_W-1:0]   buf_q, buf_d;
   logic [1:0]          j_q, j_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d, addr_q, addr_d, n_max;
   logic [WIDTH_Q-1:0]  e_q, e_d, e_s;
   logic                valid_q, valid_d, done_q, done_d, err_q, err_d, lvl_ok;
   sample #(.WIDTH_Q(WIDTH_Q)) u_sample (
      .i_r        (buf_q[WIDTH_Q*j_q +: WIDTH_Q]),
      .i_sec_level(lvl_q),
      .o_e        (e_s)
   );
   assign n_max = (lvl_q == 3'd3) ? ADDR_W'(7808) : (lvl_q == 3'd5) ? ADDR_W'(10752) : ADDR_W'(5120);
   assign lvl_ok = (i_sec_level == 3'd1) || (i_sec_level == 3'd3) || (i_sec_level == 3'd5);
   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      buf_d   = buf_q;
      j_d     = j_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      e_d     = e_q;
      valid_d = valid_q && !i_e_ready;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE: if (i_start) begin
            lvl_d   = i_sec_level;
            cnt_d   = '0;
            err_d   = !lvl_ok;
            state_d = lvl_ok ? LOAD : DONE;
         end
         LOAD: if (i_rand_valid) begin
            buf_d   = i_rand;
            j_d     = 2'd0;
            state_d = EMIT;
         end
         EMIT: if (!valid_q || i_e_ready) begin
            e_d     = e_s;
            addr_d  = cnt_q;
            valid_d = 1'b1;
            cnt_d   = cnt_q + ADDR_W'(1);
            j_d     = j_q + 2'd1;
            if (j_q == 2'd3) state_d = (cnt_d < n_max) ? LOAD : DONE;
         end
         DONE: if (!valid_q || i_e_ready) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         lvl_q   <= '0;
         buf_q   <= '0;
         j_q     <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         e_q     <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
         buf_q   <= buf_d;
         j_q     <= j_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         e_q     <= e_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end
   assign o_rand_ready = (state_q == LOAD);
   assign o_busy       = (state_q != IDLE);
   assign o_e          = e_q;
   assign o_e_addr     = addr_q;
   assign o_e_valid    = valid_q;
   assign o_done       = done_q;
   assign o_err        = err_q;
endmodule

// File: tb/tb_sample_ctrl.sv
// tb_sample_ctrl: randomized stream checks of sample_ctrl against a CDF reference model.
module tb_sample_ctrl;
   logic        i_clk = 1'b0;
   logic        i_rst_n, i_start, i_rand_valid, i_e_ready;
   logic [2:0]  i_sec_level;
   logic [63:0] i_rand;
   logic        o_rand_ready, o_e_valid, o_busy, o_done, o_err;
   logic [15:0] o_e;
   logic [13:0] o_e_addr;

   sample_ctrl dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_sec_level(i_sec_level),
      .i_rand(i_rand), .i_rand_valid(i_rand_valid), .o_rand_ready(o_rand_ready),
      .o_e(o_e), .o_e_addr(o_e_addr), .o_e_valid(o_e_valid), .i_e_ready(i_e_ready),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   int compared = 0, mismatched = 0;
   int cur_lvl = 1, exp_addr = 0, n_hs = 0, n_words = 0, n_done = 0, last_addr = -1;
   logic [15:0] rq[$];
   logic        stall_q = 1'b0;
   logic [15:0] e_prev = '0;
   logic [13:0] a_prev = '0;

   function automatic logic [15:0] ref_e(input logic [15:0] r, input int lvl);
      int cdf[$];
      int t, mag;
      if (lvl == 3) cdf = '{5638, 15915, 23689, 28571, 31116, 32217, 32613, 32731, 32760, 32766, 32767};
      else if (lvl == 5) cdf = '{9142, 23462, 30338, 32361, 32725, 32765, 32767};
      else cdf = '{4643, 13363, 20579, 25843, 29227, 31145, 32103, 32525, 32689, 32745, 32762, 32766, 32767};
      t = int'(r) / 2;
      mag = cdf.size();
      for (int i = cdf.size() - 1; i >= 0; i--) if (t <= cdf[i]) mag = i;
      return r[0] ? 16'(-mag) : 16'(mag);
   endfunction

   function automatic int n_of(input int lvl);
      return (lvl == 3) ? 7808 : (lvl == 5) ? 10752 : 5120;
   endfunction

   always @(negedge i_clk) begin
      if (!i_rst_n) stall_q <= 1'b0;
      else begin
         if (stall_q) begin
            compared++;
            if (o_e !== e_prev || o_e_addr !== a_prev || o_e_valid !== 1'b1) begin
               mismatched++;
               $display("FAIL stall_hold: got e=%h addr=%0d v=%b required e=%h addr=%0d v=1", o_e, o_e_addr, o_e_valid, e_prev, a_prev);
            end
         end
         if (o_rand_ready && (!o_busy || o_done)) begin
            compared++;
            mismatched++;
            $display("FAIL rand_ready_outside_load: got busy=%b done=%b required busy=1 done=0", o_busy, o_done);
         end
         if (o_e_valid && i_e_ready) begin
            logic [15:0] r, x;
            compared++;
            if (rq.size() == 0) begin
               mismatched++;
               $display("FAIL sample_no_word: got addr=%0d with empty model queue required none", o_e_addr);
            end else begin
               r = rq.pop_front();
               x = ref_e(r, cur_lvl);
               if (o_e !== x || o_e_addr !== exp_addr[13:0]) begin
                  mismatched++;
                  $display("FAIL sample: r=%h got e=%h addr=%0d required e=%h addr=%0d", r, o_e, o_e_addr, x, exp_addr);
               end
            end
            last_addr = int'(o_e_addr);
            exp_addr++;
            n_hs++;
         end
         if (o_rand_ready && i_rand_valid) begin
            n_words++;
            for (int k = 0; k < 4; k++) rq.push_back(i_rand[16*k +: 16]);
         end
         if (o_done) n_done++;
         stall_q <= o_e_valid && !i_e_ready;
         e_prev  <= o_e;
         a_prev  <= o_e_addr;
      end
   end

   task automatic clear_model();
      rq.delete();
      exp_addr = 0; n_hs = 0; n_words = 0; n_done = 0; last_addr = -1;
   endtask

   task automatic reset_dut();
      i_rst_n = 1'b0; i_start = 1'b0; i_rand_valid = 1'b0; i_e_ready = 1'b0; i_rand = '0; i_sec_level = '0;
      repeat (2) @(posedge i_clk);
      clear_model();
      #1 i_rst_n = 1'b1;
   endtask

   task automatic pulse_start(input int lvl);
      @(posedge i_clk); #1;
      i_start = 1'b1; i_sec_level = 3'(lvl);
      @(posedge i_clk); #1;
      i_start = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_start = 1'b0; i_rand_valid = 1'b1; i_e_ready = 1'b1; i_rand = '1; i_sec_level = 3'd1;
      @(negedge i_clk);
      compared++;
      if ({o_rand_ready, o_e, o_e_addr, o_e_valid, o_busy, o_done, o_err} !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: got rr=%b e=%h a=%0d v=%b b=%b d=%b err=%b required all 0",
                  o_rand_ready, o_e, o_e_addr, o_e_valid, o_busy, o_done, o_err);
      end
      reset_dut();
   endtask

   task automatic test_directed();
      logic [15:0] x1 [4] = '{16'hFFF4, 16'h000C, 16'h0000, 16'h0000};
      logic [15:0] x2 [4] = '{16'h0000, 16'h0001, 16'h0000, 16'h0000};
      reset_dut();
      cur_lvl = 1;
      i_rand = 64'h0000_0001_FFFE_FFFF; i_rand_valid = 1'b1; i_e_ready = 1'b1;
      pulse_start(1);
      @(negedge i_clk);
      compared++;
      if (o_rand_ready !== 1'b1 || o_e_valid !== 1'b0 || o_busy !== 1'b1) begin
         mismatched++;
         $display("FAIL dir_load: got rr=%b v=%b b=%b required rr=1 v=0 b=1", o_rand_ready, o_e_valid, o_busy);
      end
      @(posedge i_clk); #1 i_rand = 64'h0000_0000_2448_2446;
      @(negedge i_clk);
      compared++;
      if (o_e_valid !== 1'b0 || o_rand_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL dir_latency: got v=%b rr=%b required v=0 rr=0", o_e_valid, o_rand_ready);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge i_clk);
         compared++;
         if (o_e_valid !== 1'b1 || o_e !== x1[k] || o_e_addr !== 14'(k)) begin
            mismatched++;
            $display("FAIL dir_word1[%0d]: got v=%b e=%h a=%0d required v=1 e=%h a=%0d", k, o_e_valid, o_e, o_e_addr, x1[k], k);
         end
      end
      @(negedge i_clk);
      compared++;
      if (o_e_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL dir_bubble: got v=%b required 0", o_e_valid);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge i_clk);
         compared++;
         if (o_e_valid !== 1'b1 || o_e !== x2[k] || o_e_addr !== 14'(k + 4)) begin
            mismatched++;
            $display("FAIL dir_word2[%0d]: got v=%b e=%h a=%0d required v=1 e=%h a=%0d", k, o_e_valid, o_e, o_e_addr, x2[k], k + 4);
         end
      end
   endtask

   task automatic test_full(input int lvl, input int rdy_pct);
      int  n, cyc;
      bit  fin;
      reset_dut();
      cur_lvl = lvl;
      n = n_of(lvl);
      pulse_start(lvl);
      fin = 1'b0;
      cyc = 0;
      while (!fin && cyc < 40000) begin
         i_rand = {$urandom, $urandom};
         i_rand_valid = ($urandom_range(0, 99) < 70);
         i_e_ready = ($urandom_range(0, 99) < rdy_pct);
         @(posedge i_clk); #1;
         cyc++;
         if (n_done > 0) fin = 1'b1;
      end
      i_e_ready = 1'b1;
      repeat (8) @(posedge i_clk);
      #1;
      compared++;
      if (!fin) begin
         mismatched++;
         $display("FAIL full_timeout_l%0d: got no o_done after %0d cycles required o_done", lvl, cyc);
      end
      compared++;
      if (n_hs != n || n_words != n / 4 || last_addr != n - 1) begin
         mismatched++;
         $display("FAIL full_counts_l%0d: got hs=%0d words=%0d last=%0d required hs=%0d words=%0d last=%0d",
                  lvl, n_hs, n_words, last_addr, n, n / 4, n - 1);
      end
      compared++;
      if (n_done != 1 || o_busy !== 1'b0 || o_err !== 1'b0 || rq.size() != 0) begin
         mismatched++;
         $display("FAIL full_end_l%0d: got done=%0d busy=%b err=%b left=%0d required 1 0 0 0",
                  lvl, n_done, o_busy, o_err, rq.size());
      end
   endtask

   task automatic test_bad_level();
      reset_dut();
      i_rand_valid = 1'b1; i_e_ready = 1'b1; i_rand = {$urandom, $urandom};
      pulse_start(2);
      @(negedge i_clk);
      compared++;
      if (o_busy !== 1'b1 || o_rand_ready !== 1'b0 || o_e_valid !== 1'b0 || o_done !== 1'b0) begin
         mismatched++;
         $display("FAIL bad_level_busy: got b=%b rr=%b v=%b d=%b required 1 0 0 0", o_busy, o_rand_ready, o_e_valid, o_done);
      end
      @(negedge i_clk);
      compared++;
      if (o_done !== 1'b1 || o_err !== 1'b1 || o_rand_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL bad_level_done: got d=%b err=%b rr=%b required d=1 err=1 rr=0", o_done, o_err, o_rand_ready);
      end
      @(negedge i_clk);
      compared++;
      if (o_done !== 1'b0 || o_err !== 1'b1 || o_busy !== 1'b0 || n_words != 0 || n_hs != 0) begin
         mismatched++;
         $display("FAIL bad_level_after: got d=%b err=%b b=%b words=%0d hs=%0d required 0 1 0 0 0",
                  o_done, o_err, o_busy, n_words, n_hs);
      end
      cur_lvl = 1;
      pulse_start(1);
      @(negedge i_clk);
      compared++;
      if (o_err !== 1'b0 || o_busy !== 1'b1) begin
         mismatched++;
         $display("FAIL err_clear: got err=%b b=%b required err=0 b=1", o_err, o_busy);
      end
   endtask

   task automatic test_abort();
      int cyc;
      reset_dut();
      cur_lvl = 3;
      i_rand_valid = 1'b1; i_e_ready = 1'b1; i_rand = {$urandom, $urandom};
      pulse_start(3);
      cyc = 0;
      while (!(o_e_valid && o_e_addr >= 14'd50) && cyc < 1000) begin
         @(negedge i_clk);
         i_rand = {$urandom, $urandom};
         cyc++;
      end
      pulse_start(5);
      @(negedge i_clk);
      compared++;
      if (o_err !== 1'b0 || o_busy !== 1'b1) begin
         mismatched++;
         $display("FAIL start_while_busy: got err=%b b=%b required err=0 b=1", o_err, o_busy);
      end
      while (!(o_e_valid && o_e_addr == 14'd100) && cyc < 1000) begin
         @(negedge i_clk);
         cyc++;
      end
      compared++;
      if (cyc >= 1000) begin
         mismatched++;
         $display("FAIL abort_reach_100: got addr=%0d required 100", o_e_addr);
      end
      #2 i_rst_n = 1'b0;
      #1;
      compared++;
      if ({o_rand_ready, o_e, o_e_addr, o_e_valid, o_busy, o_done, o_err} !== '0 || n_done != 0) begin
         mismatched++;
         $display("FAIL abort_async: got rr=%b e=%h a=%0d v=%b b=%b d=%b err=%b dones=%0d required all 0",
                  o_rand_ready, o_e, o_e_addr, o_e_valid, o_busy, o_done, o_err, n_done);
      end
      clear_model();
      cur_lvl = 1;
      @(posedge i_clk); #1 i_rst_n = 1'b1;
      pulse_start(1);
      cyc = 0;
      while (!o_e_valid && cyc < 20) begin
         @(negedge i_clk);
         cyc++;
      end
      compared++;
      if (o_e_valid !== 1'b1 || o_e_addr !== 14'd0) begin
         mismatched++;
         $display("FAIL restart_addr: got v=%b a=%0d required v=1 a=0", o_e_valid, o_e_addr);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_full(1, 100);
      test_full(3, 50);
      test_full(5, 75);
      test_bad_level();
      test_abort();
      reset_dut();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/sample_ctrl.md
Name: sample_ctrl

Overview:
- Sequencing controller for the combinational error sampler `sample`; instantiates it internally.
- Pulls 64-bit random words from the SHAKE/PRNG stream and splits each word into four 16-bit r values.
- Drives each r value through `sample` and emits the sign-extended error samples (o_e_16 form) on a valid/ready stream, with a linear write address.
- Produces exactly n*nbar samples for the selected security level. This fills one error matrix (S, E, E' or E'') for the matrix-arithmetic RAM writer.

Parameters:
- RAND_W, 64, width of the random input word; must be 4*WIDTH_Q.
- WIDTH_Q, `L5_WIDTH_Q (16), width of the r input and of the emitted sample.
- ADDR_W, 14, width of the sample address/counter; must cover 10752.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle start pulse; accepted only in IDLE.
- i_sec_level  in  3  security level, 1/3/5; latched on accepted i_start.
- i_rand  in  RAND_W  random word; bits [15:0] are consumed first.
- i_rand_valid  in  1  i_rand is valid.
- o_rand_ready  out  1  controller accepts i_rand this cycle.
- o_e  out  WIDTH_Q  sign-extended error sample, two's complement.
- o_e_addr  out  ADDR_W  sample index 0..N-1, aligned with o_e.
- o_e_valid  out  1  o_e/o_e_addr valid.
- i_e_ready  in  1  downstream accepts the sample.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse at completion.
- o_err  out  1  unsupported sec level; sticky until the next accepted i_start.

Behaviour:
- Reset (async, any state): FSM to IDLE; counters and word buffer to 0.
  - All outputs 0: o_rand_ready, o_e, o_e_addr, o_e_valid, o_busy, o_done, o_err.
- N is 5120 for level 1, 7808 for level 3, 10752 for level 5. Every N is divisible by 4.
- Level handling:
  - The latched level drives the i_sec_level input of `sample`.
  - Any level other than 1/3/5 goes IDLE->DONE: o_err set, no random words consumed, no samples emitted.
- FSM states: IDLE, LOAD, EMIT, DONE.
- IDLE:
  - On i_start: latch the level, clear the sample counter and o_err, go to LOAD (or DONE if the level is invalid).
  - i_start in any other state is ignored.
- LOAD:
  - o_rand_ready=1 only in this state.
  - On i_rand_valid: capture i_rand into the word buffer, sub-index j=0, go to EMIT.
- EMIT:
  - `sample` is fed buffer[16j+15:16j].
  - The output register loads when (!o_e_valid || i_e_ready). Each load takes sample(r_j) into o_e, the counter into o_e_addr, sets o_e_valid=1, increments the counter and increments j.
  - After the load with j=3: go to LOAD if counter+1<N, else go to DONE.
- Output stream rules:
  - While o_e_valid && !i_e_ready, o_e/o_e_addr/o_e_valid hold and j does not advance.
  - o_e_valid drops after a handshake with no new load.
- DONE:
  - Wait until the final sample handshakes (o_e_valid==0 or i_e_ready==1).
  - Then pulse o_done for 1 cycle and return to IDLE.
- Latency and throughput:
  - Random word accepted at edge t: first sample visible after edge t+1; samples 2..4 on the following edges if i_e_ready=1.
  - Throughput is 4 samples per 5 cycles (one LOAD bubble per word).
- Sample arithmetic (implemented by `sample`):
  - t=r>>1; e = count of table entries T[i] with t>T[i]; negate e if r[0]=1; sign-extend to WIDTH_Q.
  - -0 is emitted as 0x0000.
- Addresses are strictly sequential 0..N-1 with no gaps or repeats, regardless of backpressure.
- Reset asserted mid-operation aborts immediately: no o_done, and a partial matrix is discarded by the system.

Test Plan:
- Level 1, i_rand=0x0000_0001_FFFE_FFFF on the first word, i_e_ready=1 -> first four o_e are 0xFFF4, 0x000C, 0x0000, 0x0000 at addr 0..3, o_e_valid first high 2 edges after the start pulse plus 1 LOAD cycle.
- Level 1, i_rand=0x0000_0000_2448_2446 -> o_e 0x0000, 0x0001 (t=4644>4643), 0x0000, 0x0000.
- Full runs at levels 1/3/5 with random i_rand_valid gaps -> exactly 5120/7808/10752 handshakes, addr last = N-1, exactly 1280/1952/2688 words consumed, single o_done pulse; every o_e matches the reference sample model.
- Random i_e_ready deassertion (50%) -> o_e/o_e_addr stable while stalled, no sample lost or duplicated, o_rand_ready never high outside LOAD.
- i_sec_level=2 with i_start -> o_err=1, o_done pulse 2 cycles after start, o_rand_ready and o_e_valid never asserted; next valid start clears o_err.
- Assert i_rst_n=0 during EMIT at addr 100 -> all outputs 0 asynchronously, no o_done; a new start restarts at addr 0. i_start while busy has no effect.
